// File: rtl/riscv_du_rf_port.sv
// Debug-side register-file access engine: stalls the core, performs one GPR read or
// write through the debug port, and returns exactly one response per accepted request.
module riscv_du_rf_port #(
    parameter int unsigned XLEN          = 32,
    parameter int unsigned AR_BITS       = 5,
    parameter int unsigned STALL_TIMEOUT = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [11:0]     req_addr,
    input  logic [XLEN-1:0] req_wdata,
    input  logic            req_hold,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_rdata,
    output logic            rsp_err,
    output logic            du_stall,
    input  logic            core_stalled,
    output logic [11:0]     du_addr,
    output logic [XLEN-1:0] du_dato,
    output logic            du_we_rf,
    input  logic [XLEN-1:0] du_dati_rf
);

    localparam int unsigned CntW = $clog2(STALL_TIMEOUT);
    localparam logic [CntW-1:0] CntLast = CntW'(STALL_TIMEOUT - 1);

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StStall  = 2'd1,
        StAccess = 2'd2,
        StResp   = 2'd3
    } state_e;

    state_e          r_state, w_state_d;
    logic [CntW-1:0] r_cnt, w_cnt_d;
    logic            r_we, w_we_d;
    logic            r_hold, w_hold_d;
    logic            r_stall, w_stall_d;
    logic            r_du_we, w_du_we_d;
    logic [11:0]     r_du_addr, w_du_addr_d;
    logic [XLEN-1:0] r_du_dato, w_du_dato_d;
    logic [XLEN-1:0] r_rsp_rdata, w_rsp_rdata_d;
    logic            r_rsp_err, w_rsp_err_d;

    logic            w_req_oor;
    logic            w_req_idx_zero;
    logic            w_idx_zero;

    // Anything above the GPR index field addresses a register this port does not reach.
    assign w_req_oor      = |req_addr[11:AR_BITS];
    assign w_req_idx_zero = (req_addr[AR_BITS-1:0] == '0);
    assign w_idx_zero     = (r_du_addr[AR_BITS-1:0] == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= StIdle;
            r_cnt       <= '0;
            r_we        <= 1'b0;
            r_hold      <= 1'b0;
            r_stall     <= 1'b0;
            r_du_we     <= 1'b0;
            r_du_addr   <= '0;
            r_du_dato   <= '0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_cnt       <= w_cnt_d;
            r_we        <= w_we_d;
            r_hold      <= w_hold_d;
            r_stall     <= w_stall_d;
            r_du_we     <= w_du_we_d;
            r_du_addr   <= w_du_addr_d;
            r_du_dato   <= w_du_dato_d;
            r_rsp_rdata <= w_rsp_rdata_d;
            r_rsp_err   <= w_rsp_err_d;
        end
    end

    always_comb begin
        w_state_d     = r_state;
        w_cnt_d       = r_cnt;
        w_we_d        = r_we;
        w_hold_d      = r_hold;
        w_stall_d     = r_stall;
        w_du_we_d     = 1'b0;
        w_du_addr_d   = r_du_addr;
        w_du_dato_d   = r_du_dato;
        w_rsp_rdata_d = r_rsp_rdata;
        w_rsp_err_d   = r_rsp_err;

        unique case (r_state)
            StIdle: begin
                if (req_valid) begin
                    w_we_d      = req_we;
                    w_hold_d    = req_hold;
                    w_du_addr_d = req_addr;
                    w_cnt_d     = '0;
                    if (req_we && !w_req_oor) begin
                        w_du_dato_d = req_wdata;
                    end
                    if (w_req_oor) begin
                        w_state_d     = StResp;
                        w_rsp_err_d   = 1'b1;
                        w_rsp_rdata_d = '0;
                    end else if (r_stall && core_stalled) begin
                        // Core still parked from a held access: skip the stall handshake.
                        w_state_d = StAccess;
                        w_du_we_d = req_we && !w_req_idx_zero;
                    end else begin
                        w_state_d = StStall;
                        w_stall_d = 1'b1;
                    end
                end
            end

            StStall: begin
                if (core_stalled) begin
                    w_state_d = StAccess;
                    w_cnt_d   = '0;
                    w_du_we_d = r_we && !w_idx_zero;
                end else if (r_cnt == CntLast) begin
                    w_state_d     = StResp;
                    w_cnt_d       = '0;
                    w_stall_d     = 1'b0;
                    w_rsp_err_d   = 1'b1;
                    w_rsp_rdata_d = '0;
                end else begin
                    w_cnt_d = r_cnt + 1'b1;
                end
            end

            StAccess: begin
                w_state_d     = StResp;
                w_rsp_err_d   = 1'b0;
                w_rsp_rdata_d = (!r_we && !w_idx_zero) ? du_dati_rf : '0;
            end

            StResp: begin
                if (rsp_ready) begin
                    w_state_d = StIdle;
                    w_stall_d = r_stall & r_hold;
                end
            end

            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    assign req_ready = (r_state == StIdle);
    assign rsp_valid = (r_state == StResp);
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;
    assign du_stall  = r_stall;
    assign du_addr   = r_du_addr;
    assign du_dato   = r_du_dato;
    assign du_we_rf  = r_du_we;

    // The write strobe may only ever coincide with the single access cycle of a stalled core.
    a_we_in_access : assert property (@(posedge clk) disable iff (rst)
        r_du_we |-> (r_state == StAccess) && r_stall);
    a_one_outstanding : assert property (@(posedge clk) disable iff (rst)
        rsp_valid |-> !req_ready);

endmodule

// File: tb/tb_riscv_du_rf_port.sv
// Randomised bench for riscv_du_rf_port: a transaction-level model predicts every
// output cycle by cycle; directed cases pin latencies and data with literal values.
module tb_riscv_du_rf_port;

    localparam int XLEN = 32;
    localparam int AR   = 5;
    localparam int T    = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [11:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        req_hold = 1'b0;
    logic        rsp_ready = 1'b0;
    logic        req_ready, rsp_valid, rsp_err, du_stall, du_we_rf, core_stalled;
    logic [31:0] rsp_rdata, du_dato, du_dati_rf;
    logic [11:0] du_addr;

    // Environment: register file and core stall-acknowledge behaviour.
    logic [31:0] rf_env [32];
    logic        env_loaded = 1'b0;
    int          stall_cnt = 0;
    logic        ack_en = 1'b0;
    int          ack_dly = 0;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    // Transaction-level model state.
    logic        m_loaded = 1'b0, m_rst_chk = 1'b0;
    logic        m_busy = 1'b0, m_held = 1'b0, m_wr = 1'b0, m_err = 1'b0;
    logic        m_to = 1'b0, m_range = 1'b0, m_hold = 1'b0;
    int          m_acc = 0, m_lat = 0;
    logic [11:0] m_addr = '0;
    logic [31:0] m_wdata = '0, m_rdata = '0;
    logic [31:0] gold [32];

    riscv_du_rf_port #(
        .XLEN          (XLEN),
        .AR_BITS       (AR),
        .STALL_TIMEOUT (T)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_hold     (req_hold),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .du_stall     (du_stall),
        .core_stalled (core_stalled),
        .du_addr      (du_addr),
        .du_dato      (du_dato),
        .du_we_rf     (du_we_rf),
        .du_dati_rf   (du_dati_rf)
    );

    always #5 clk = ~clk;

    assign core_stalled = ack_en && du_stall && (stall_cnt >= ack_dly);
    assign du_dati_rf   = rf_env[du_addr[4:0]];

    function automatic logic [31:0] init_val(input int i);
        if (i == 0) return 32'h0;
        if (i == 5) return 32'hDEADBEEF;
        return (32'(i) * 32'h01010101) ^ 32'hA5A50000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) begin : env
        stall_cnt <= du_stall ? stall_cnt + 1 : 0;
        if (!env_loaded) begin
            for (int i = 0; i < 32; i++) rf_env[i] <= init_val(i);
            env_loaded <= 1'b1;
        end else if (du_we_rf && du_addr[4:0] != 5'd0) begin
            rf_env[du_addr[4:0]] <= du_dato;
        end
    end

    always @(posedge clk) begin : model
        logic oor, fast, tmo;
        int   lat, idx;
        cyc <= cyc + 1;
        if (!m_loaded) begin
            for (int i = 0; i < 32; i++) gold[i] <= init_val(i);
            m_loaded <= 1'b1;
        end
        if (rst) begin
            m_busy    <= 1'b0;
            m_held    <= 1'b0;
            m_addr    <= '0;
            m_rst_chk <= 1'b1;
        end else begin
            m_rst_chk <= 1'b0;
            if (!m_busy && req_valid) begin
                idx  = int'(req_addr[4:0]);
                oor  = (req_addr[11:5] != 7'd0);
                fast = !oor && m_held && core_stalled;
                tmo  = !oor && !fast && !(ack_en && ack_dly <= T - 1);
                lat  = oor ? 0 : fast ? 1 : tmo ? T : ack_dly + 2;
                m_busy  <= 1'b1;
                m_acc   <= cyc + 1;
                m_lat   <= lat;
                m_range <= oor;
                m_to    <= tmo;
                m_err   <= oor || tmo;
                m_hold  <= req_hold;
                m_addr  <= req_addr;
                m_wdata <= req_wdata;
                m_wr    <= req_we && !oor && !tmo && idx != 0;
                m_rdata <= (!req_we && !oor && !tmo && idx != 0) ? gold[idx] : 32'h0;
            end else if (m_busy) begin
                if (m_wr && cyc == m_acc + m_lat - 1) gold[m_addr[4:0]] <= m_wdata;
                if (cyc >= m_acc + m_lat && rsp_ready) begin
                    m_busy <= 1'b0;
                    m_held <= m_hold && (m_range ? m_held : !m_to);
                end
            end
        end
    end

    always @(negedge clk) begin : compare
        logic rv, st, we_exp;
        if (m_rst_chk) begin
            chk("rst_req_ready", req_ready, 1);
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_rsp_rdata", rsp_rdata, 0);
            chk("rst_rsp_err", rsp_err, 0);
            chk("rst_du_stall", du_stall, 0);
            chk("rst_du_we_rf", du_we_rf, 0);
            chk("rst_du_addr", du_addr, 0);
            chk("rst_du_dato", du_dato, 0);
        end else if (m_loaded) begin
            rv     = m_busy && (cyc >= m_acc + m_lat);
            st     = !m_busy ? m_held : m_range ? m_held : (rv && m_to) ? 1'b0 : 1'b1;
            we_exp = m_busy && m_wr && (cyc == m_acc + m_lat - 1);
            chk("req_ready", req_ready, !m_busy);
            chk("rsp_valid", rsp_valid, rv);
            if (rv) begin
                chk("rsp_rdata", rsp_rdata, m_rdata);
                chk("rsp_err", rsp_err, m_err);
            end
            chk("du_stall", du_stall, st);
            chk("du_we_rf", du_we_rf, we_exp);
            if (we_exp) chk("du_dato", du_dato, m_wdata);
            chk("du_addr", du_addr, m_addr);
        end
    end

    // Called on a negedge; returns on the negedge after the response handshake.
    task automatic send(input logic we, input logic [11:0] addr, input logic [31:0] wdata,
                        input logic hold, input logic aen, input int adly, input int rdly,
                        output logic [31:0] rd, output logic er, output int lat);
        int n;
        ack_en    = aen;
        ack_dly   = adly;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_hold  = hold;
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("accept_wait", req_ready, 1);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        if (lat >= 200) chk("rsp_wait", rsp_valid, 1);
        rd = rsp_rdata;
        er = rsp_err;
        repeat (rdly) @(negedge clk);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;

        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Read x5, core acknowledges three cycles after the stall request.
        send(1'b0, 12'h005, 32'h0, 1'b0, 1'b1, 3, 0, rd, er, lat);
        chk("x5_rdata", rd, 32'hDEADBEEF);
        chk("x5_err", er, 0);
        chk("x5_lat", lat, 5);
        chk("x5_stall_drop", du_stall, 0);

        // Write x7 with immediate acknowledge, then read it back.
        send(1'b1, 12'h007, 32'h12345678, 1'b0, 1'b1, 0, 1, rd, er, lat);
        chk("w7_err", er, 0);
        chk("w7_lat", lat, 2);
        send(1'b0, 12'h007, 32'h0, 1'b0, 1'b1, 0, 0, rd, er, lat);
        chk("r7_rdata", rd, 32'h12345678);

        // x0 write is dropped silently; x0 reads as zero.
        send(1'b1, 12'h000, 32'hFFFFFFFF, 1'b0, 1'b1, 0, 0, rd, er, lat);
        chk("w0_err", er, 0);
        send(1'b0, 12'h000, 32'h0, 1'b0, 1'b1, 1, 0, rd, er, lat);
        chk("r0_rdata", rd, 32'h0);

        // Out-of-range address answers immediately with an error.
        send(1'b1, 12'h020, 32'h55AA55AA, 1'b0, 1'b1, 0, 2, rd, er, lat);
        chk("oor_err", er, 1);
        chk("oor_lat", lat, 0);
        chk("oor_rdata", rd, 32'h0);

        // Core never acknowledges: timeout error and stall released.
        send(1'b0, 12'h005, 32'h0, 1'b0, 1'b0, 0, 0, rd, er, lat);
        chk("to_err", er, 1);
        chk("to_lat", lat, T);
        chk("to_rdata", rd, 32'h0);
        chk("to_stall", du_stall, 0);

        // Acknowledge on the last permitted cycle, and one cycle too late.
        send(1'b0, 12'h005, 32'h0, 1'b0, 1'b1, T - 1, 0, rd, er, lat);
        chk("late_ok_err", er, 0);
        chk("late_ok_lat", lat, T + 1);
        chk("late_ok_rdata", rd, 32'hDEADBEEF);
        send(1'b0, 12'h005, 32'h0, 1'b0, 1'b1, T, 0, rd, er, lat);
        chk("too_late_err", er, 1);
        chk("too_late_lat", lat, T);

        // Held stall: second access goes straight to the register file.
        send(1'b0, 12'h005, 32'h0, 1'b1, 1'b1, 0, 0, rd, er, lat);
        chk("hold1_lat", lat, 2);
        chk("hold1_stall_kept", du_stall, 1);
        send(1'b0, 12'h007, 32'h0, 1'b0, 1'b1, 0, 5, rd, er, lat);
        chk("hold2_lat", lat, 1);
        chk("hold2_rdata", rd, 32'h12345678);
        chk("hold2_stall_drop", du_stall, 0);

        // Reset in the middle of a stalled write aborts it.
        ack_en    = 1'b0;
        req_we    = 1'b1;
        req_addr  = 12'h003;
        req_wdata = 32'hCAFEF00D;
        req_hold  = 1'b0;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        chk("mid_stall", du_stall, 1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_stall", du_stall, 0);
        chk("abort_rsp_valid", rsp_valid, 0);
        chk("abort_req_ready", req_ready, 1);
        chk("abort_du_addr", du_addr, 0);
        send(1'b0, 12'h003, 32'h0, 1'b0, 1'b1, 0, 0, rd, er, lat);
        chk("abort_x3_intact", rd, 32'hA6A60303);

        // Randomised traffic checked cycle by cycle by the model.
        for (int i = 0; i < 150; i++) begin
            logic        we, hold, aen;
            logic [11:0] addr;
            int          idx, adly, rdly;
            we   = 1'($urandom_range(0, 1));
            idx  = $urandom_range(0, 31);
            addr = 12'(idx);
            if ($urandom_range(0, 9) == 0) addr = {7'($urandom_range(1, 127)), 5'(idx)};
            hold = ($urandom_range(0, 3) == 0);
            aen  = ($urandom_range(0, 9) != 0);
            adly = ($urandom_range(0, 14) == 0) ? $urandom_range(T - 2, T + 1)
                                                : $urandom_range(0, 4);
            rdly = $urandom_range(0, 3);
            if (m_held) begin
                aen  = 1'b1;
                adly = 0;
            end
            send(we, addr, $urandom, hold, aen, adly, rdly, rd, er, lat);
        end

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
